// File: rtl/seq_div_32by16.sv
// Sequential restoring divider: 32-bit dividend by 16-bit divisor, one quotient
// bit per clock, with start/busy/done handshake and divide-by-zero/overflow flags.
module seq_div_32by16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] DIVIDEND,
  input  logic [15:0] DIVISOR,
  output logic [15:0] Q,
  output logic [15:0] R,
  output logic        busy,
  output logic        done,
  output logic        dz,
  output logic        ovf
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FINISH
  } state_t;

  state_t      r_state;
  logic [15:0] r_dreg;
  logic [15:0] r_rem;
  logic [15:0] r_qsh;
  logic [3:0]  r_cnt;
  logic [15:0] r_q;
  logic [15:0] r_r;
  logic        r_busy;
  logic        r_done;
  logic        r_dz;
  logic        r_ovf;

  logic [16:0] w_trial;
  logic        w_ge;
  logic [15:0] w_diff;
  logic [15:0] w_remNext;
  logic [15:0] w_qshNext;

  // rem < dreg holds throughout CALC, so the difference always fits in 16 bits
  assign w_trial   = {r_rem, r_qsh[15]};
  assign w_ge      = (w_trial >= {1'b0, r_dreg});
  assign w_diff    = w_trial[15:0] - r_dreg;
  assign w_remNext = w_ge ? w_diff : w_trial[15:0];
  assign w_qshNext = {r_qsh[14:0], w_ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_dreg  <= 16'h0000;
      r_rem   <= 16'h0000;
      r_qsh   <= 16'h0000;
      r_cnt   <= 4'd0;
      r_q     <= 16'h0000;
      r_r     <= 16'h0000;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_dreg <= DIVISOR;
            r_dz   <= 1'b0;
            r_ovf  <= 1'b0;
            if (DIVISOR == 16'h0000) begin
              r_dz    <= 1'b1;
              r_q     <= 16'hFFFF;
              r_r     <= 16'h0000;
              r_done  <= 1'b1;
              r_state <= FINISH;
            end else if (DIVIDEND[31:16] >= DIVISOR) begin
              r_ovf   <= 1'b1;
              r_q     <= 16'hFFFF;
              r_r     <= 16'h0000;
              r_done  <= 1'b1;
              r_state <= FINISH;
            end else begin
              r_rem   <= DIVIDEND[31:16];
              r_qsh   <= DIVIDEND[15:0];
              r_cnt   <= 4'd0;
              r_busy  <= 1'b1;
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_rem <= w_remNext;
          r_qsh <= w_qshNext;
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            r_q     <= w_qshNext;
            r_r     <= w_remNext;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= FINISH;
          end
        end
        FINISH: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign Q    = r_q;
  assign R    = r_r;
  assign busy = r_busy;
  assign done = r_done;
  assign dz   = r_dz;
  assign ovf  = r_ovf;

endmodule
